// File: rtl/wb_broadcast_queue.sv
// ---------------------------------------------------------------------------
// wb_broadcast_queue
//
// Writeback collection queue that sits between the execution units and the
// reservation stations. Up to NUM_IN results per cycle are compacted in
// channel order and stored in a circular buffer. Up to NUM_OUT of the oldest
// entries are re-emitted per cycle on registered broadcast lanes.
//
// Optional feature (macro WB_BYPASS_EN):
//   When the queue is empty and no flush is in progress, up to NUM_OUT valid
//   inputs are loaded directly into the output registers. This cuts latency
//   to one cycle for those entries. Only the remaining inputs are enqueued.
//   With the macro undefined, every input goes through the buffer.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset, has priority over flush
//   flush        drop every queued and incoming entry
//   in_en        per-channel valid, NUM_IN bits
//   in_vregid    NUM_IN x VREG_W; channel i is at [i*VREG_W +: VREG_W]
//   in_val       NUM_IN x DATA_W; channel i is at [i*DATA_W +: DATA_W]
//   out_en       per-lane broadcast valid, NUM_OUT bits; lane 0 is the oldest
//   out_vregid   NUM_OUT x VREG_W, packed the same way as the inputs
//   out_val      NUM_OUT x DATA_W, packed the same way as the inputs
//   count        registered occupancy (0..DEPTH)
//   almost_full  registered; high when fewer than NUM_IN entries are free
//   overflow     sticky; set when an input had to be dropped, cleared by rst
// ---------------------------------------------------------------------------
module wb_broadcast_queue #(
    parameter int NUM_IN  = 3,
    parameter int NUM_OUT = 1,
    parameter int DEPTH   = 32,
    parameter int VREG_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_IN-1:0]         in_en,
    input  logic [NUM_IN*VREG_W-1:0]  in_vregid,
    input  logic [NUM_IN*DATA_W-1:0]  in_val,
    output logic [NUM_OUT-1:0]        out_en,
    output logic [NUM_OUT*VREG_W-1:0] out_vregid,
    output logic [NUM_OUT*DATA_W-1:0] out_val,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      almost_full,
    output logic                      overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Storage
    logic [VREG_W-1:0] r_mem_id  [DEPTH];
    logic [DATA_W-1:0] r_mem_val [DEPTH];

    // Pointers and occupancy. The queue is full when count == DEPTH, which
    // the pointers alone cannot tell apart from empty.
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    // Registered outputs
    logic [NUM_OUT-1:0]        r_out_en;
    logic [NUM_OUT*VREG_W-1:0] r_out_id;
    logic [NUM_OUT*DATA_W-1:0] r_out_val;
    logic                      r_af;
    logic                      r_ovf;

    // Per-cycle decisions
    int                w_deq;
    int                w_free;
    int                w_acc;
    int                w_rank;
    int                w_cnt_nxt;
    logic              w_bypass;
    logic              w_drop;
    logic [NUM_IN-1:0] w_wr;
    logic [PW-1:0]     w_wr_idx  [NUM_IN];
    logic [NUM_OUT-1:0] w_byp;
    int                w_byp_src [NUM_OUT];

    always_comb begin
        w_deq  = (int'(r_count) < NUM_OUT) ? int'(r_count) : NUM_OUT;
        // Slots freed by this cycle's dequeue can be refilled in the same
        // cycle. The reads use the pre-edge memory contents.
        w_free = DEPTH - int'(r_count) + w_deq;
`ifdef WB_BYPASS_EN
        w_bypass = (r_count == '0) && !flush;
`else
        w_bypass = 1'b0;
`endif
        w_acc  = 0;
        w_rank = 0;
        w_drop = 1'b0;
        w_wr   = '0;
        w_byp  = '0;
        for (int i = 0; i < NUM_IN; i++) w_wr_idx[i] = '0;
        for (int j = 0; j < NUM_OUT; j++) w_byp_src[j] = 0;

        // Compact the valid channels in ascending order. The lowest channels
        // claim the bypass lanes first, then queue slots. Channels that get
        // neither are the highest-index ones, and they are dropped.
        for (int i = 0; i < NUM_IN; i++) begin
            if (in_en[i]) begin
                if (w_bypass && w_rank < NUM_OUT) begin
                    w_byp[w_rank]     = 1'b1;
                    w_byp_src[w_rank] = i;
                end else if (w_acc < w_free) begin
                    w_wr[i]     = 1'b1;
                    w_wr_idx[i] = r_tail + PW'(w_acc);
                    w_acc       = w_acc + 1;
                end else begin
                    w_drop = 1'b1;
                end
                w_rank = w_rank + 1;
            end
        end

        w_cnt_nxt = int'(r_count) - w_deq + w_acc;
    end

    // Control state and output lanes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_out_en  <= '0;
            r_out_id  <= '0;
            r_out_val <= '0;
            r_af      <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (flush) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_out_en <= '0;
            r_af     <= 1'b0;
        end else begin
            r_head  <= r_head + PW'(w_deq);
            r_tail  <= r_tail + PW'(w_acc);
            r_count <= CW'(w_cnt_nxt);
            r_af    <= (DEPTH - w_cnt_nxt) < NUM_IN;
            if (w_drop) r_ovf <= 1'b1;

            // Dequeue and bypass never overlap: bypass only happens when
            // count == 0, and then w_deq is 0.
            for (int j = 0; j < NUM_OUT; j++) begin
                if (j < w_deq) begin
                    r_out_en[j]                       <= 1'b1;
                    r_out_id[j*VREG_W +: VREG_W]      <= r_mem_id[r_head + PW'(j)];
                    r_out_val[j*DATA_W +: DATA_W]     <= r_mem_val[r_head + PW'(j)];
                end else if (w_byp[j]) begin
                    r_out_en[j]                       <= 1'b1;
                    r_out_id[j*VREG_W +: VREG_W]      <= in_vregid[w_byp_src[j]*VREG_W +: VREG_W];
                    r_out_val[j*DATA_W +: DATA_W]     <= in_val[w_byp_src[j]*DATA_W +: DATA_W];
                end else begin
                    r_out_en[j] <= 1'b0;
                end
            end
        end
    end

    // Buffer writes. There is no reset: an entry is only read after it has
    // been written.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (w_wr[i]) begin
                    r_mem_id[w_wr_idx[i]]  <= in_vregid[i*VREG_W +: VREG_W];
                    r_mem_val[w_wr_idx[i]] <= in_val[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign out_en      = r_out_en;
    assign out_vregid  = r_out_id;
    assign out_val     = r_out_val;
    assign count       = r_count;
    assign almost_full = r_af;
    assign overflow    = r_ovf;

endmodule
